// File: rtl/sw_encoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sw_encoder_pkg                                                  |
// | Purpose  : Shared types and constants for the 16-switch encoder: vector    |
// |            and code widths, event FSM state type, encoded-result struct    |
// |            and the encode helper (highest set index, none, multi).         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package sw_encoder_pkg;

   localparam int c_code_w = 4;
   localparam int c_vec_w  = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   typedef struct packed {
      logic [c_code_w-1:0] code;
      logic                none;
      logic                multi;
   } enc_t;

   // Value presented after reset: "nothing pressed".
   localparam enc_t c_enc_rst = '{code: '0, none: 1'b1, multi: 1'b0};

   // Highest-index priority encode plus none/multi flags.
   function automatic enc_t encode(input logic [c_vec_w-1:0] v);
      enc_t       r;
      logic [4:0] ones;
      r.code = '0;
      ones   = '0;
      for (int i = 0; i < c_vec_w; i++) begin
         if (v[i]) r.code = c_code_w'(i);
         ones = ones + {4'd0, v[i]};
      end
      r.none  = (v == '0);
      r.multi = (ones > 5'd1);
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sw_encoder16x4_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sw_debounce                                                     |
// | Purpose  : 2-FF synchronizer followed by a whole-vector debouncer. The     |
// |            candidate vector must stay unchanged for DEBOUNCE_CYCLES clocks |
// |            before it is committed as the new stable vector.                |
// | Ports    : clk      - system clock                                         |
// |            rst_n    - asynchronous active-low reset                        |
// |            i_sw     - raw asynchronous switch vector                       |
// |            o_cand   - current candidate (debounce) vector                  |
// |            o_commit - one-cycle strobe: o_cand is committed on this edge   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sw_debounce
   import sw_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [c_vec_w-1:0] i_sw,
   output logic [c_vec_w-1:0] o_cand,
   output logic               o_commit
);

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [c_vec_w-1:0] r_s1;
   logic [c_vec_w-1:0] r_s2;
   logic [c_vec_w-1:0] r_cand;
   logic [c_vec_w-1:0] r_stable;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_commit;

   // Commit once the candidate has survived the full count and differs from
   // what is already committed; a revert to the stable value never commits.
   assign w_commit = (r_s2 == r_cand) && (r_cnt == c_cnt_last) && (r_cand != r_stable);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1     <= '0;
         r_s2     <= '0;
         r_cand   <= '0;
         r_stable <= '0;
         r_cnt    <= '0;
      end else begin
         r_s1 <= i_sw;
         r_s2 <= r_s1;
         if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= '0;
         end else if (r_cnt != c_cnt_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_commit) r_stable <= r_cand;
      end
   end

   assign o_cand   = r_cand;
   assign o_commit = w_commit;

endmodule
`default_nettype wire

// File: rtl/sw_encoder16x4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sw_encoder16x4                                                  |
// | Purpose  : 16 slide switches -> 4-bit index of the highest active switch,  |
// |            with none/multi flags, plus a valid/ready event per commit.     |
// | Ports    : clk_100MHz - system clock                                       |
// |            reset_n    - asynchronous active-low reset                      |
// |            sw         - raw switches (asynchronous)                        |
// |            code/none/multi          - committed encode result            |
// |            evt_valid/evt_ready      - event handshake                     |
// |            evt_code/evt_none/evt_multi - event payload                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sw_encoder16x4
   import sw_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic                clk_100MHz,
   input  logic                reset_n,
   input  logic [c_vec_w-1:0]  sw,
   output logic [c_code_w-1:0] code,
   output logic                none,
   output logic                multi,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [c_code_w-1:0] evt_code,
   output logic                evt_none,
   output logic                evt_multi
);

   logic [c_vec_w-1:0] w_cand;
   logic               w_commit;
   enc_t               w_enc;

   state_t r_state, w_state_nxt;
   enc_t   r_out;
   enc_t   r_evt, w_evt_nxt;
   enc_t   r_shadow, w_shadow_nxt;
   logic   r_pend, w_pend_nxt;

   sw_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk      (clk_100MHz),
      .rst_n    (reset_n),
      .i_sw     (sw),
      .o_cand   (w_cand),
      .o_commit (w_commit)
   );

   assign w_enc = encode(w_cand);

   // Event FSM: HOLD keeps the offered event frozen until accepted; commits
   // arriving meanwhile collapse into a single newest-value shadow slot.
   always_comb begin
      w_state_nxt  = r_state;
      w_evt_nxt    = r_evt;
      w_shadow_nxt = r_shadow;
      w_pend_nxt   = r_pend;
      case (r_state)
         IDLE: begin
            if (w_commit) begin
               w_evt_nxt   = w_enc;
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (evt_ready) begin
               w_pend_nxt = 1'b0;
               if (w_commit) begin
                  // Same-edge commit is newer than anything in the shadow.
                  w_evt_nxt = w_enc;
               end else if (r_pend) begin
                  w_evt_nxt = r_shadow;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (w_commit) begin
               w_shadow_nxt = w_enc;
               w_pend_nxt   = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_out    <= c_enc_rst;
         r_evt    <= c_enc_rst;
         r_shadow <= c_enc_rst;
         r_pend   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_evt    <= w_evt_nxt;
         r_shadow <= w_shadow_nxt;
         r_pend   <= w_pend_nxt;
         if (w_commit) r_out <= w_enc;
      end
   end

   assign code      = r_out.code;
   assign none      = r_out.none;
   assign multi     = r_out.multi;
   // Valid is purely the state register, so it never depends on evt_ready
   // and drops immediately with the asynchronous reset.
   assign evt_valid = (r_state == HOLD);
   assign evt_code  = r_evt.code;
   assign evt_none  = r_evt.none;
   assign evt_multi = r_evt.multi;

endmodule
`default_nettype wire

// File: tb/tb_sw_encoder16x4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sw_encoder16x4                                               |
// | Purpose  : Self-checking bench for sw_encoder16x4 with DEBOUNCE_CYCLES=4:  |
// |            directed scenarios plus random switch/ready traffic checked     |
// |            every clock against a sample-history reference model.          |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sw_encoder16x4;

   localparam int c_dc = 4;

   logic        clk_100MHz = 1'b0;
   logic        reset_n    = 1'b0;
   logic [15:0] sw         = '0;
   logic        evt_ready  = 1'b0;
   logic [3:0]  code, evt_code;
   logic        none, multi, evt_valid, evt_none, evt_multi;

   int n_checks = 0;
   int n_pass   = 0;

   sw_encoder16x4 #(.DEBOUNCE_CYCLES(c_dc), .CNT_W(3)) dut (
      .clk_100MHz (clk_100MHz),
      .reset_n    (reset_n),
      .sw         (sw),
      .code       (code),
      .none       (none),
      .multi      (multi),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_code   (evt_code),
      .evt_none   (evt_none),
      .evt_multi  (evt_multi)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Expected result of a vector: {code, none, multi}, code = floor(log2(v)).
   function automatic logic [5:0] menc(input logic [15:0] v);
      int t, c;
      t = v;
      c = 0;
      while (t > 1) begin
         t = t >> 1;
         c++;
      end
      return {c[3:0], (v == 16'h0), ($countones(v) > 1)};
   endfunction

   logic [15:0] hist[$];   // raw samples, oldest first
   logic [15:0] m_stable;
   logic [5:0]  m_out, m_ev, m_pend_val;
   bit          m_have_ev, m_have_pend;

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < c_dc + 2; i++) hist.push_back(16'h0);
      m_stable    = '0;
      m_out       = 6'b0000_10;
      m_ev        = 6'b0000_10;
      m_pend_val  = 6'b0000_10;
      m_have_ev   = 0;
      m_have_pend = 0;
   endtask

   // A sample becomes committed once DEBOUNCE_CYCLES+1 consecutive samples,
   // ending two edges ago (synchronizer), agree and differ from the stable one.
   task automatic model_edge();
      bit          eq, commit, hs;
      logic [15:0] v;
      if (!reset_n) begin
         model_reset();
         return;
      end
      hs = m_have_ev && evt_ready;
      hist.push_back(sw);
      v  = hist[0];
      eq = 1;
      for (int i = 1; i <= c_dc; i++) if (hist[i] != v) eq = 0;
      void'(hist.pop_front());
      commit = eq && (v != m_stable);
      if (commit) begin
         m_stable = v;
         m_out    = menc(v);
      end
      if (!m_have_ev) begin
         if (commit) begin
            m_ev      = menc(v);
            m_have_ev = 1;
         end
      end else if (hs) begin
         if (commit)           m_ev = menc(v);
         else if (m_have_pend) m_ev = m_pend_val;
         else                  m_have_ev = 0;
         m_have_pend = 0;
      end else if (commit) begin
         m_pend_val  = menc(v);
         m_have_pend = 1;
      end
   endtask

   task automatic check_all();
      chk("enc", {10'd0, code, none, multi}, {10'd0, m_out});
      chk("evt_valid", {15'd0, evt_valid}, {15'd0, m_have_ev});
      chk("evt", {10'd0, evt_code, evt_none, evt_multi}, {10'd0, m_ev});
   endtask

   task automatic tick();
      @(posedge clk_100MHz);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic settle(input int n);
      repeat (n) tick();
   endtask

   task automatic ack();
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
   endtask

   initial begin
      model_reset();
      // Reset with all switches on.
      sw = 16'hFFFF;
      settle(3);
      chk("rst_code", {12'd0, code}, 16'd0);
      chk("rst_none", {15'd0, none}, 16'd1);
      chk("rst_multi", {15'd0, multi}, 16'd0);
      chk("rst_valid", {15'd0, evt_valid}, 16'd0);
      sw      = 16'h0;
      reset_n = 1'b1;
      settle(20);
      chk("rst_idle_valid", {15'd0, evt_valid}, 16'd0);

      // Clean press: commit on the 7th edge after the change.
      sw = 16'h0020;
      settle(6);
      chk("press_early", {15'd0, evt_valid}, 16'd0);
      tick();
      chk("press_code", {12'd0, code}, 16'd5);
      chk("press_evt_code", {12'd0, evt_code}, 16'd5);
      chk("press_valid", {15'd0, evt_valid}, 16'd1);
      ack();
      chk("press_ack", {15'd0, evt_valid}, 16'd0);

      // Bounce on sw[9] (sw[5] released first).
      sw = 16'h0;
      settle(8);
      ack();
      for (int i = 0; i < 6; i++) begin
         sw = (i % 2 == 0) ? 16'h0200 : 16'h0000;
         settle(2);
      end
      sw = 16'h0200;
      settle(6);
      chk("bounce_early", {15'd0, evt_valid}, 16'd0);
      tick();
      chk("bounce_code", {12'd0, evt_code}, 16'd9);
      ack();

      // Multi / priority.
      sw = 16'h8001;
      settle(8);
      chk("multi_code", {12'd0, code}, 16'd15);
      chk("multi_flag", {14'd0, none, multi}, 16'b01);
      ack();
      sw = 16'h0001;
      settle(8);
      chk("bit0_code", {10'd0, code, none, multi}, 16'd0);
      ack();
      sw = 16'h0000;
      settle(8);
      chk("zero_code", {10'd0, code, none, multi}, 16'b10);
      ack();

      // Backpressure: 3, 7, 12 committed while held.
      sw = 16'h0008; settle(8);
      sw = 16'h0080; settle(8);
      sw = 16'h1000; settle(8);
      chk("bp_hold", {12'd0, evt_code}, 16'd3);
      evt_ready = 1'b1;
      tick();
      chk("bp_hs1_code", {12'd0, evt_code}, 16'd12);
      chk("bp_hs1_valid", {15'd0, evt_valid}, 16'd1);
      tick();
      evt_ready = 1'b0;
      chk("bp_hs2_valid", {15'd0, evt_valid}, 16'd0);

      // Asynchronous reset mid-HOLD with a pending event.
      sw = 16'h0002; settle(8);
      sw = 16'h0004; settle(8);
      chk("ar_pre_valid", {15'd0, evt_valid}, 16'd1);
      reset_n = 1'b0;
      #1;
      chk("ar_valid_now", {15'd0, evt_valid}, 16'd0);
      chk("ar_enc_now", {10'd0, code, none, multi}, 16'b10);
      model_reset();
      sw = 16'h0;
      settle(3);
      reset_n = 1'b1;
      settle(20);
      chk("ar_no_evt", {15'd0, evt_valid}, 16'd0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0: sw = 16'($urandom);
               1: sw = 16'h1 << $urandom_range(0, 15);
               default: sw = 16'h0;
            endcase
         end
         evt_ready = ($urandom_range(0, 3) == 0);
         tick();
      end
      evt_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
